// File: rtl/gerenciador_ataque_sync_pkg.sv
// Shared constants and combinational helpers for the battleship attack manager.
package gerenciador_ataque_sync_pkg;

    localparam int NUM_COLUNAS = 5;
    localparam int NUM_LINHAS  = 7;

    // Status LED codes, ordered {LED_R, LED_G, LED_B}
    localparam logic [2:0] COR_ACERTO  = 3'b010;
    localparam logic [2:0] COR_ERRO    = 3'b100;
    localparam logic [2:0] COR_APAGADO = 3'b000;

    // 3-bit to 8-line one-hot decoder; codes above the grid size select
    // lines that no cell listens to, so they naturally change nothing.
    function automatic logic [7:0] decodificador_3bits(input logic [2:0] sel);
        logic [7:0] linhas;
        case (sel)
            3'd0:    linhas = 8'b0000_0001;
            3'd1:    linhas = 8'b0000_0010;
            3'd2:    linhas = 8'b0000_0100;
            3'd3:    linhas = 8'b0000_1000;
            3'd4:    linhas = 8'b0001_0000;
            3'd5:    linhas = 8'b0010_0000;
            3'd6:    linhas = 8'b0100_0000;
            3'd7:    linhas = 8'b1000_0000;
            default: linhas = 8'b0000_0000;
        endcase
        return linhas;
    endfunction

    // Per-cell 2:1 select: keep the current bit unless the cell is targeted.
    function automatic logic mux_2x1(input logic a, input logic b, input logic sel);
        logic y;
        if (sel) begin
            y = b;
        end else begin
            y = a;
        end
        return y;
    endfunction

    // Full-map equality compare of current vs. next revealed map.
    function automatic logic comparador_de_igualdade(input logic [34:0] a, input logic [34:0] b);
        return (a == b);
    endfunction

endpackage

// File: rtl/gerenciador_ataque_sync_detector_borda_subida.sv
// Synchronous rising-edge detector: pulso is high for the cycle in which
// sinal is high and was low at the previous clock edge.
module detector_borda_subida (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);

    logic sinal_q_r;

    // Remember the level of sinal seen at the previous edge
    always_ff @(posedge clock) begin
        if (reset) begin
            sinal_q_r <= 1'b0;
        end else begin
            sinal_q_r <= sinal;
        end
    end

    // Pulse is combinational so the consumer can act on the same edge
    always_comb begin
        pulso = sinal & ~sinal_q_r;
    end

endmodule

// File: rtl/gerenciador_ataque_sync.sv
// Attack manager for the 5x7 LED-matrix battleship game: keeps the revealed
// map, copies the targeted secret cell on each shot and shows the result
// on the RGB status LED.
module gerenciador_ataque_sync
    import gerenciador_ataque_sync_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] coordColuna,
    input  logic [2:0] coordLinha,
    input  logic       enable,
    input  logic       confirmar,
    input  logic [6:0] mapa0,
    input  logic [6:0] mapa1,
    input  logic [6:0] mapa2,
    input  logic [6:0] mapa3,
    input  logic [6:0] mapa4,
    output logic [6:0] matriz0,
    output logic [6:0] matriz1,
    output logic [6:0] matriz2,
    output logic [6:0] matriz3,
    output logic [6:0] matriz4,
    output logic       LED_R,
    output logic       LED_G,
    output logic       LED_B
);

    logic [NUM_COLUNAS-1:0][NUM_LINHAS-1:0] matriz_r;
    logic [NUM_COLUNAS-1:0][NUM_LINHAS-1:0] matriz_prox_s;
    logic [NUM_COLUNAS-1:0][NUM_LINHAS-1:0] mapa_s;
    logic [2:0] cor_r;
    logic [2:0] cor_prox_s;
    logic [7:0] sel_coluna_s;
    logic [7:0] sel_linha_s;
    logic       limpar_s;
    logic       disparo_s;
    logic       igual_s;

    // Disabling the game clears exactly like reset, edge history included
    always_comb begin
        limpar_s = reset | ~enable;
    end

    detector_borda_subida u_detector (
        .clock (clock),
        .reset (limpar_s),
        .sinal (confirmar),
        .pulso (disparo_s)
    );

    // Next revealed map: only the cell selected by row AND column takes the
    // secret bit, so revealed bits can be set but never cleared
    always_comb begin
        mapa_s       = {mapa4, mapa3, mapa2, mapa1, mapa0};
        sel_coluna_s = decodificador_3bits(coordColuna);
        sel_linha_s  = decodificador_3bits(coordLinha);
        matriz_prox_s = matriz_r;
        for (int c = 0; c < NUM_COLUNAS; c++) begin
            for (int r = 0; r < NUM_LINHAS; r++) begin
                matriz_prox_s[c][r] = mux_2x1(matriz_r[c][r], mapa_s[c][r],
                                              sel_coluna_s[c] & sel_linha_s[r]);
            end
        end
    end

    // Shot result: any change in the map is a new hit, otherwise red
    always_comb begin
        igual_s = comparador_de_igualdade(matriz_r, matriz_prox_s);
        if (igual_s) begin
            cor_prox_s = COR_ERRO;
        end else begin
            cor_prox_s = COR_ACERTO;
        end
    end

    // Revealed map and LED state; clear beats a simultaneous shot
    always_ff @(posedge clock) begin
        if (limpar_s) begin
            matriz_r <= '0;
            cor_r    <= COR_APAGADO;
        end else if (disparo_s) begin
            matriz_r <= matriz_prox_s;
            cor_r    <= cor_prox_s;
        end else begin
            matriz_r <= matriz_r;
            cor_r    <= cor_r;
        end
    end

    assign matriz0 = matriz_r[0];
    assign matriz1 = matriz_r[1];
    assign matriz2 = matriz_r[2];
    assign matriz3 = matriz_r[3];
    assign matriz4 = matriz_r[4];
    assign {LED_R, LED_G, LED_B} = cor_r;

endmodule

// File: tb/tb_gerenciador_ataque_sync.sv
// Directed self-checking bench for gerenciador_ataque_sync.
module tb_gerenciador_ataque_sync;

    logic       clock;
    logic       reset;
    logic [2:0] coordColuna;
    logic [2:0] coordLinha;
    logic       enable;
    logic       confirmar;
    logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
    logic [6:0] matriz0, matriz1, matriz2, matriz3, matriz4;
    logic       LED_R, LED_G, LED_B;

    int testes_s;
    int falhas_s;

    gerenciador_ataque_sync dut (
        .clock       (clock),
        .reset       (reset),
        .coordColuna (coordColuna),
        .coordLinha  (coordLinha),
        .enable      (enable),
        .confirmar   (confirmar),
        .mapa0       (mapa0),
        .mapa1       (mapa1),
        .mapa2       (mapa2),
        .mapa3       (mapa3),
        .mapa4       (mapa4),
        .matriz0     (matriz0),
        .matriz1     (matriz1),
        .matriz2     (matriz2),
        .matriz3     (matriz3),
        .matriz4     (matriz4),
        .LED_R       (LED_R),
        .LED_G       (LED_G),
        .LED_B       (LED_B)
    );

    // 10 ns clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic verificar(input string tag, input logic [34:0] obs, input logic [34:0] esp);
        testes_s++;
        if (obs !== esp) begin
            falhas_s++;
            $display("FAIL %s: got %h expected %h", tag, obs, esp);
        end
    endtask

    // Compare whole map {matriz4..matriz0} and LEDs {R,G,B}
    task automatic checar(input string tag, input logic [34:0] esp_mapa, input logic [2:0] esp_cor);
        verificar({tag, "_matriz"}, {matriz4, matriz3, matriz2, matriz1, matriz0}, esp_mapa);
        verificar({tag, "_led"}, {32'd0, LED_R, LED_G, LED_B}, {32'd0, esp_cor});
    endtask

    // One shot: rising edge of confirmar for one clock, then release
    task automatic disparar(input logic [2:0] c, input logic [2:0] r);
        @(negedge clock);
        coordColuna = c;
        coordLinha  = r;
        confirmar   = 1'b1;
        @(negedge clock);
        confirmar   = 1'b0;
        @(negedge clock);
    endtask

    logic [34:0] esp_s;

    initial begin
        testes_s    = 0;
        falhas_s    = 0;
        reset       = 1'b1;
        enable      = 1'b1;
        confirmar   = 1'b0;
        coordColuna = 3'd0;
        coordLinha  = 3'd0;
        mapa0 = 7'b1110001;
        mapa1 = 7'b0100000;
        mapa2 = 7'b0000000;
        mapa3 = 7'b0000000;
        mapa4 = 7'b1110000;

        // 1: reset two cycles
        @(negedge clock);
        @(negedge clock);
        checar("reset", 35'd0, 3'b000);
        reset = 1'b0;

        // 2: basic shots
        esp_s = 35'd0;
        disparar(3'd0, 3'd0);
        esp_s[0] = 1'b1;                      // matriz0 = 0000001
        checar("tiro_0_0", esp_s, 3'b010);
        disparar(3'd0, 3'd1);
        checar("tiro_0_1_agua", esp_s, 3'b100);
        disparar(3'd1, 3'd5);
        esp_s[7 + 5] = 1'b1;                  // matriz1 = 0100000
        checar("tiro_1_5", esp_s, 3'b010);
        disparar(3'd3, 3'd5);
        checar("tiro_3_5_agua", esp_s, 3'b100);
        disparar(3'd4, 3'd6);
        esp_s[28 + 6] = 1'b1;                 // matriz4 = 1000000
        checar("tiro_4_6", esp_s, 3'b010);

        // 3: repeat hit, then hold confirmar on a fresh hit for 5 cycles
        disparar(3'd0, 3'd0);
        checar("repetido_0_0", esp_s, 3'b100);
        @(negedge clock);
        coordColuna = 3'd4;
        coordLinha  = 3'd5;
        confirmar   = 1'b1;
        esp_s[28 + 5] = 1'b1;                 // matriz4 = 1100000
        @(negedge clock);
        checar("segura_1", esp_s, 3'b010);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
        end
        checar("segura_5", esp_s, 3'b010);    // a second shot would turn red
        confirmar = 1'b0;
        @(negedge clock);

        // 4: out-of-range coordinates
        disparar(3'd5, 3'd0);
        checar("fora_coluna", esp_s, 3'b100);
        disparar(3'd1, 3'd0);                 // mapa1[0]=0: water, still red
        disparar(3'd1, 3'd5);                 // repeat, red
        disparar(3'd0, 3'd7);
        checar("fora_linha", esp_s, 3'b100);

        // 5: enable low for one cycle clears everything
        @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        enable = 1'b1;
        checar("enable_baixo", 35'd0, 3'b000);
        disparar(3'd0, 3'd0);
        checar("pos_enable_0_0", 35'd1, 3'b010);

        // 6: reset together with a confirmar rising edge
        disparar(3'd1, 3'd5);
        esp_s = 35'd1;
        esp_s[7 + 5] = 1'b1;
        checar("pre_reset", esp_s, 3'b010);
        @(negedge clock);
        coordColuna = 3'd4;
        coordLinha  = 3'd4;
        reset       = 1'b1;
        confirmar   = 1'b1;
        @(negedge clock);
        checar("reset_com_tiro", 35'd0, 3'b000);
        reset     = 1'b0;
        confirmar = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checar("pos_reset", 35'd0, 3'b000);

        $display("[TB] %0d tests run, %0d failed", testes_s, falhas_s);
        $finish;
    end

endmodule
